// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// op encodings, FSM state type and op classification helpers.
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_MADD  = 3'd2;
  localparam logic [2:0] MD_MADDU = 3'd3;
  localparam logic [2:0] MD_MSUB  = 3'd4;
  localparam logic [2:0] MD_MSUBU = 3'd5;
  localparam logic [2:0] MD_DIV   = 3'd6;
  localparam logic [2:0] MD_DIVU  = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Even op codes are the signed variants.
  function automatic logic is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit for the EX stage. Works on operand
// magnitudes, applies sign fix and Hi/Lo accumulation when entering DONE.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Flush,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] HiIn,
  input  logic [WIDTH-1:0] LoIn,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  md_state_e state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   hi_in_q, lo_in_q, a_raw_q, b_mag_q;
  logic               sa_q, sb_q, bzero_q;
  logic [2*WIDTH-1:0] mc_q, acc_q;
  logic [WIDTH-1:0]   mp_q, quo_q, rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dbz_q;

  logic               accept, iter_last;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     r_sh, diff;
  logic [2*WIDTH-1:0] prod, res;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept    = (state_q == MD_IDLE) && Start && !Flush;
  assign iter_last = (state_q == MD_RUN) && (cnt_q == LAST);

  assign a_neg = is_signed(Op) && A[WIDTH-1];
  assign b_neg = is_signed(Op) && B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // Restoring divide step: shift in next dividend bit, trial-subtract divisor.
  assign r_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff = r_sh - {1'b0, b_mag_q};

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (accept) state_d = MD_RUN;
      MD_RUN: begin
        if (Flush)          state_d = MD_IDLE;
        else if (iter_last) state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    Busy  = (state_q == MD_RUN) || (state_q == MD_DONE);
    Stall = accept || (state_q == MD_RUN);
    Done  = (state_q == MD_DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset)                           cnt_q <= '0;
    else if (accept)                     cnt_q <= '0;
    else if (state_q == MD_RUN && !iter_last) cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      op_q    <= Op;
      hi_in_q <= HiIn;
      lo_in_q <= LoIn;
      a_raw_q <= A;
      b_mag_q <= b_mag;
      sa_q    <= a_neg;
      sb_q    <= b_neg;
      bzero_q <= (B == '0);
      mc_q    <= {{WIDTH{1'b0}}, a_mag};
      mp_q    <= b_mag;
      acc_q   <= '0;
      quo_q   <= a_mag;
      rem_q   <= '0;
    end else if (state_q == MD_RUN && !iter_last) begin
      mc_q  <= mc_q << 1;
      mp_q  <= mp_q >> 1;
      acc_q <= acc_q + (mp_q[0] ? mc_q : '0);
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= r_sh[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fix and accumulation, consumed on the RUN->DONE edge.
  always_comb begin
    prod    = (is_signed(op_q) && (sa_q ^ sb_q)) ? -acc_q : acc_q;
    quo_fix = (is_signed(op_q) && (sa_q ^ sb_q)) ? -quo_q : quo_q;
    rem_fix = (is_signed(op_q) && sa_q) ? -rem_q : rem_q;
    res     = prod;
    case (op_q)
      MD_MADD, MD_MADDU: res = {hi_in_q, lo_in_q} + prod;
      MD_MSUB, MD_MSUBU: res = {hi_in_q, lo_in_q} - prod;
      MD_DIV, MD_DIVU:   res = bzero_q ? {a_raw_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
      default:           res = prod;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      dbz_q <= 1'b0;
    end else if (iter_last && !Flush) begin
      hi_q  <= res[2*WIDTH-1:WIDTH];
      lo_q  <= res[WIDTH-1:0];
      dbz_q <= is_div(op_q) && bzero_q;
    end
  end

  assign HiOut     = hi_q;
  assign LoOut     = lo_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected {DivByZero,Hi,Lo} queued at
// issue, popped and compared whenever Done is seen.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset, Start, Flush;
  logic [2:0]   Op;
  logic [W-1:0] A, B, HiIn, LoIn;
  logic         Busy, Stall, Done, DivByZero;
  logic [W-1:0] HiOut, LoOut;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  logic [64:0] sb_q[$];

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Flush(Flush), .Op(Op),
    .A(A), .B(B), .HiIn(HiIn), .LoIn(LoIn),
    .Busy(Busy), .Stall(Stall), .Done(Done),
    .HiOut(HiOut), .LoOut(LoOut), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    sp = sa * sb;
    p  = is_signed(op) ? sp : ({32'd0, a} * {32'd0, b});
    case (op)
      MD_MADD, MD_MADDU: return {1'b0, {hi, lo} + p};
      MD_MSUB, MD_MSUBU: return {1'b0, {hi, lo} - p};
      MD_DIV, MD_DIVU: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == MD_DIV) begin
          logic signed [63:0] q, r;
          q = sa / sb;
          r = sa % sb;
          return {1'b0, r[31:0], q[31:0]};
        end
        return {1'b0, a % b, a / b};
      end
      default: return {1'b0, p};
    endcase
  endfunction

  // Scoreboard consumer.
  always @(negedge Clk) begin
    if (Done) begin
      n_done++;
      if (sb_q.size() == 0) check("unexpected_done", 65'd1, 65'd0);
      else check("result", {DivByZero, HiOut, LoOut}, sb_q.pop_front());
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge Clk);
    while (Busy && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (Busy) check("idle_timeout", 65'd1, 65'd0);
  endtask

  // Drive Start for one edge (E0); the expected result is queued only when push is set.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo,
                       input logic [64:0] exp, input bit push);
    wait_idle();
    Op = op; A = a; B = b; HiIn = hi; LoIn = lo; Start = 1'b1;
    if (push) sb_q.push_back(exp);
    #1 check("stall_at_e0", {64'd0, Stall}, 65'd1);
    @(posedge Clk);
    #1 Start = 1'b0;
    A = $urandom; B = $urandom; HiIn = $urandom; LoIn = $urandom;
  endtask

  // Counts cycles after E0 until Done, and how many of them had Stall high.
  task automatic wait_done(output int cyc, output int stalls);
    cyc = 0; stalls = 0;
    while (cyc < 60) begin
      @(negedge Clk);
      cyc++;
      if (Done) break;
      if (Stall) stalls++;
    end
    if (!Done) check("done_timeout", 65'd1, 65'd0);
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                     input logic [64:0] exp);
    int cyc, st;
    issue(op, a, b, hi, lo, exp, 1'b1);
    wait_done(cyc, st);
    check({tag, "_latency"}, 65'(cyc), 65'd34);
    check({tag, "_stall_cycles"}, 65'(st), 65'd33);
    check({tag, "_stall_in_done"}, {64'd0, Stall}, 65'd0);
  endtask

  initial begin
    int cyc, st, d0;
    logic [64:0] kept;
    Reset = 1'b1; Start = 1'b0; Flush = 1'b0; Op = '0;
    A = '0; B = '0; HiIn = '0; LoIn = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("reset_state", {Busy, Done, DivByZero, HiOut, LoOut[28:0]}, 65'd0);
    check("reset_lo", {33'd0, LoOut}, 65'd0);

    run("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0, {1'b0, 64'hFFFF_FFFF_FFFF_FFEB});
    run("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, {1'b0, 64'hFFFF_FFFE_0000_0001});
    run("madd", MD_MADD, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, {1'b0, 64'h0000_0001_0000_0000});
    run("msub", MD_MSUB, 32'd2, 32'd3, 32'd0, 32'd0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFA});
    run("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
    run("divu", MD_DIVU, 32'd100, 32'd7, 0, 0, {1'b0, 64'h0000_0002_0000_000E});
    run("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, {1'b0, 64'h0000_0000_8000_0000});
    run("divu_zero", MD_DIVU, 32'd5, 32'd0, 0, 0, {1'b1, 64'h0000_0005_FFFF_FFFF});
    run("divu_after_zero", MD_DIVU, 32'd9, 32'd3, 0, 0, {1'b0, 64'h0000_0000_0000_0003});
    run("div_zero_signed", MD_DIV, 32'hFFFF_FF00, 32'd0, 0, 0, {1'b1, 64'hFFFF_FF00_FFFF_FFFF});

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb, rh, rl;
      logic [2:0] rop;
      rop = 3'(i);
      ra = $urandom; rb = $urandom; rh = $urandom; rl = $urandom;
      if (i == 7) rb = rb >> 20;
      issue(rop, ra, rb, rh, rl, model(rop, ra, rb, rh, rl), 1'b1);
      wait_done(cyc, st);
    end

    // Reset partway through RUN: no Done and everything cleared.
    issue(MD_MULTU, 32'd123, 32'd456, 0, 0, '0, 1'b0);
    repeat (9) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    check("reset_in_run", {Busy, Done, DivByZero, HiOut, LoOut[28:0]}, 65'd0);
    check("reset_in_run_lo", {33'd0, LoOut}, 65'd0);
    repeat (40) @(negedge Clk);
    check("reset_in_run_idle", {64'd0, Busy}, 65'd0);

    // Flush partway through RUN: results keep last completed values.
    kept = {1'b0, 64'h0000_0002_0000_000E};
    run("pre_flush", MD_DIVU, 32'd100, 32'd7, 0, 0, kept);
    issue(MD_MULTU, 32'd77, 32'd88, 0, 0, '0, 1'b0);
    repeat (4) @(posedge Clk);
    #1 Flush = 1'b1;
    @(posedge Clk);
    #1 Flush = 1'b0;
    check("flush_idle", {64'd0, Busy}, 65'd0);
    repeat (40) @(negedge Clk);
    check("flush_hold", {DivByZero, HiOut, LoOut}, kept);

    // Flush in IDLE overrides Start.
    @(negedge Clk);
    Start = 1'b1; Flush = 1'b1;
    #1 check("flush_over_start_stall", {64'd0, Stall}, 65'd0);
    @(posedge Clk);
    #1 Start = 1'b0; Flush = 1'b0;
    check("flush_over_start_busy", {64'd0, Busy}, 65'd0);

    // Start pulsed during RUN is ignored: exactly one Done.
    d0 = n_done;
    issue(MD_MULTU, 32'd6, 32'd7, 0, 0, {1'b0, 64'd42}, 1'b1);
    repeat (9) @(posedge Clk);
    #1 Start = 1'b1; Op = MD_DIVU; A = 32'd1; B = 32'd1;
    @(posedge Clk);
    #1 Start = 1'b0;
    wait_done(cyc, st);
    repeat (60) @(negedge Clk);
    check("start_in_run_single_done", 65'(n_done - d0), 65'd1);

    check("scoreboard_drained", 65'(sb_q.size()), 65'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
